alu_ctrl_seq: RTL

- Next-generation ALU control for the multi-cycle MIPS datapath.
- Decodes the control-unit ALU opcode (dataUC) and the R-type funct field into a registered, width-parametrised operation code.
- Adds a sequencer for iterative MULT/DIV: launches the multiply/divide unit, stalls the pipeline for the iteration count, then pulses completion and the HI/LO write enable.
- Sits in EX between the main control unit, the ALU and the mult/div unit.

---
 rtl/alu_ctrl_seq_if.sv | 21 ++
 rtl/alu_ctrl_seq.sv | 74 +++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: EX-stage decode/sequencer bus between control, ALU and mult/div unit
interface alu_ctrl_seq_if #(parameter int OP_W = 4);
  logic            valid_in;
  logic [5:0]      Function;
  logic [2:0]      dataUC;
  logic [OP_W-1:0] Operacion;
  logic            illegal;
  logic            md_start;
  logic            md_op;
  logic            stall;
  logic            done;
  logic            hilo_we;
  modport master (
    output valid_in, Function, dataUC,
    input  Operacion, illegal, md_start, md_op, stall, done, hilo_we
  );
  modport slave (
    input  valid_in, Function, dataUC,
    output Operacion, illegal, md_start, md_op, stall, done, hilo_we
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU opcode decode plus MULT/DIV launch/stall/complete sequencer
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic          clk,
  input logic          rst,
  alu_ctrl_seq_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3;
  localparam logic [3:0] NOP = 4'hf;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q, fcode, code;
  logic          ill_q, mdop_q, is_md, accept;
  always_comb begin
    fcode = NOP;
    case (bus.Function)
      6'b100000: fcode = 4'h2;
      6'b100010: fcode = 4'h6;
      6'b100100: fcode = 4'h0;
      6'b100101: fcode = 4'h1;
      6'b100110: fcode = 4'h3;
      6'b100111: fcode = 4'hc;
      6'b101010: fcode = 4'h7;
      6'b000000: fcode = 4'h4;
      6'b000010: fcode = 4'h5;
      6'b011000: fcode = 4'h8;
      6'b011010: fcode = 4'h9;
      default:   fcode = NOP;
    endcase
    code = (bus.dataUC == 3'd0) ? 4'h2 :
           (bus.dataUC == 3'd1) ? 4'h6 :
           (bus.dataUC == 3'd2) ? fcode :
           (bus.dataUC == 3'd3) ? 4'h0 :
           (bus.dataUC == 3'd4) ? 4'h1 :
           (bus.dataUC == 3'd5) ? 4'h7 :
           (bus.dataUC == 3'd6) ? 4'h4 : NOP;
  end
  // NOP is only ever produced by an unsupported encoding, so it doubles as the illegal flag
  assign is_md  = code[3:1] == 3'b100;
  assign accept = state == IDLE || state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= NOP;
      ill_q  <= 1'b0;
      mdop_q <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.valid_in ? code : NOP;
      ill_q <= bus.valid_in && code == NOP;
      state <= (bus.valid_in && is_md) ? START : IDLE;
      if (bus.valid_in && is_md) begin
        mdop_q <= code[0];
        cnt    <= CW'(DATA_W - 1);
      end
    end else if (state == START) begin
      state <= RUN;
    end else if (cnt == '0) begin
      state <= DONE;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
  assign bus.Operacion = OP_W'(op_q);
  assign bus.illegal   = ill_q;
  assign bus.md_op     = mdop_q;
  assign bus.md_start  = state == START;
  assign bus.done      = state == DONE;
  assign bus.hilo_we   = state == DONE;
  assign bus.stall     = (accept && bus.valid_in && is_md) || state == START || state == RUN;
endmodule
